// File: rtl/mul_defs.sv
// Shared definitions for the Booth multiplier: operand width, FSM encoding
// and the Add_ctrl polarity of the CLA_8bit adder/subtractor.
package mul_defs;

  localparam int WIDTH = 8;
  localparam int ITER  = WIDTH;

  // CLA_8bit: Add_ctrl=1 adds B, Add_ctrl=0 subtracts B
  localparam logic ADD = 1'b1;
  localparam logic SUB = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/CLA_8bit.sv
// 8-bit carry-lookahead adder/subtractor built from two 4-bit lookahead
// groups. Subtraction inverts B and injects a carry of one.
module CLA_8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Add_ctrl,
  output logic [7:0] SUM,
  output logic       C_out,
  output logic       v
);

  logic [7:0] bx;
  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  // Carries c[i+1..i+4] of one 4-bit group, expanded two-level lookahead.
  function automatic logic [3:0] la4(input logic [3:0] gg, input logic [3:0] pp,
                                     input logic ci);
    logic [3:0] co;
    co[0] = gg[0] | (pp[0] & ci);
    co[1] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
    co[2] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
          | (pp[2] & pp[1] & pp[0] & ci);
    co[3] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
          | (pp[3] & pp[2] & pp[1] & gg[0]) | (pp[3] & pp[2] & pp[1] & pp[0] & ci);
    return co;
  endfunction

  assign bx     = B ^ {8{~Add_ctrl}};
  assign g      = A & bx;
  assign p      = A ^ bx;
  assign c[0]   = ~Add_ctrl;
  assign c[4:1] = la4(g[3:0], p[3:0], c[0]);
  assign c[8:5] = la4(g[7:4], p[7:4], c[4]);

  assign SUM   = p ^ c[7:0];
  assign C_out = c[8];
  assign v     = c[8] ^ c[7];

endmodule

// File: rtl/booth_mul_8bit.sv
// Sequential signed 8x8 radix-2 Booth multiplier. One Booth step per cycle
// through the shared CLA_8bit; 9 cycles from accepted start to done.
//
// state  | meaning
// S_IDLE | waiting for start
// S_CALC | 8 Booth add/sub + arithmetic shift steps, busy=1
// S_DONE | one cycle, done=1, product valid; start here chains directly
module booth_mul_8bit
  import mul_defs::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam logic [2:0] LAST = 3'(ITER - 1);

  state_t             state;
  logic [WIDTH-1:0]   m_reg;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   q;
  logic               qm1;
  logic [2:0]         count;

  logic [1:0]         booth_op;
  logic               op_step;
  logic               add_ctrl;
  logic [WIDTH-1:0]   cla_sum;
  logic               cla_v;
  logic               unused_cout;
  logic [WIDTH-1:0]   sum_p;
  logic               true_sign;
  logic [WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]   q_nxt;

  CLA_8bit u_cla (
    .A        (acc),
    .B        (m_reg),
    .Add_ctrl (add_ctrl),
    .SUM      (cla_sum),
    .C_out    (unused_cout),
    .v        (cla_v)
  );

  // Booth decode and the 17-bit arithmetic shift; the shifted-in sign is
  // corrected by the CLA overflow so acc-(-128) keeps the right sign.
  always_comb begin
    booth_op  = {q[0], qm1};
    op_step   = booth_op[1] ^ booth_op[0];
    add_ctrl  = (booth_op == 2'b01) ? ADD : SUB;
    sum_p     = op_step ? cla_sum : acc;
    true_sign = sum_p[WIDTH-1] ^ (op_step & cla_v);
    acc_nxt   = {true_sign, sum_p[WIDTH-1:1]};
    q_nxt     = {sum_p[0], q[WIDTH-1:1]};
  end

  // Control FSM, operand capture, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      m_reg   <= '0;
      acc     <= '0;
      q       <= '0;
      qm1     <= 1'b0;
      count   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            m_reg <= multiplicand;
            q     <= multiplier;
            acc   <= '0;
            qm1   <= 1'b0;
            count <= '0;
            busy  <= 1'b1;
            state <= S_CALC;
          end else begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          acc   <= acc_nxt;
          q     <= q_nxt;
          qm1   <= q[0];
          count <= count + 3'd1;
          if (count == LAST) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= {acc_nxt, q_nxt};
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_8bit.sv
// Directed bench for booth_mul_8bit: latency, signed corner products,
// start-while-busy, back-to-back chaining and reset abort.
module tb_booth_mul_8bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int checks   = 0;
  int failures = 0;

  booth_mul_8bit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // 8 CALC cycles with busy=1/done=0, then the DONE cycle; ends at DONE negedge.
  task automatic calc_phase(input string tag, input logic [15:0] exp);
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_busy"}, {15'd0, busy}, 16'd1);
      chk({tag, "_nodone"}, {15'd0, done}, 16'd0);
      @(negedge clk);
    end
    chk({tag, "_done"}, {15'd0, done}, 16'd1);
    chk({tag, "_idle_busy"}, {15'd0, busy}, 16'd0);
    chk({tag, "_product"}, product, exp);
  endtask

  task automatic run_op(input string tag, input logic [7:0] m, input logic [7:0] q,
                        input logic [15:0] exp);
    @(negedge clk);
    start = 1'b1; multiplicand = m; multiplier = q;
    @(negedge clk);
    start = 1'b0;
    calc_phase(tag, exp);
    @(negedge clk);
    chk({tag, "_pulse_end"}, {15'd0, done}, 16'd0);
    chk({tag, "_held"}, product, exp);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; multiplicand = '0; multiplier = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_product", product, 16'h0000);
    rst_n = 1'b1;

    run_op("m3q5",       8'd3,    8'd5,    16'h000F);
    run_op("m128q128",   8'h80,   8'h80,   16'h4000);
    run_op("m127q128",   8'h7F,   8'h80,   16'hC080);
    run_op("m1q1",       8'hFF,   8'hFF,   16'h0001);
    run_op("m2q3",       8'hFE,   8'hFD,   16'h0006);

    // start pulsed during CALC cycle 3 must be ignored
    @(negedge clk);
    start = 1'b1; multiplicand = 8'd2; multiplier = 8'd3;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("ign_busy", {15'd0, busy}, 16'd1);
      if (i == 2) begin start = 1'b1; multiplicand = 8'd100; multiplier = 8'd100; end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk("ign_done", {15'd0, done}, 16'd1);
    chk("ign_product", product, 16'h0006);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("ign_single_done", {15'd0, done}, 16'd0);
      chk("ign_no_recapture", {15'd0, busy}, 16'd0);
    end

    // back-to-back: start held across DONE; 5*-7=-35, then -127*127=-16129
    @(negedge clk);
    start = 1'b1; multiplicand = 8'd5; multiplier = 8'hF9;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("b2b1_busy", {15'd0, busy}, 16'd1);
      if (i == 7) begin start = 1'b1; multiplicand = 8'h81; multiplier = 8'h7F; end
      @(negedge clk);
    end
    chk("b2b1_done", {15'd0, done}, 16'd1);
    chk("b2b1_product", product, 16'hFFDD);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_held", product, 16'hFFDD);
    calc_phase("b2b2", 16'hC0FF);

    // reset during CALC cycle 5 aborts
    @(negedge clk);
    start = 1'b1; multiplicand = 8'd3; multiplier = 8'd5;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("abort_busy", {15'd0, busy}, 16'd1);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy0", {15'd0, busy}, 16'd0);
    chk("abort_done0", {15'd0, done}, 16'd0);
    chk("abort_product0", product, 16'h0000);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_done", {15'd0, done}, 16'd0);
    end

    run_op("post_m128q1", 8'h80, 8'd1, 16'hFF80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
